// File: rtl/stream_join_buffered.sv
// stream_join_buffered: buffered N-way stream join under a handshaked per-beat selection mask.
// Ports:
//    clk_i, rst_i                   clock, synchronous active-high reset
//    inp_valid_i/inp_data_i/inp_ready_o   N_INP producer streams, each into its own DEPTH-entry FIFO
//    sel_valid_i/sel_i/sel_ready_o        selection mask stream, one mask per output beat
//    oup_valid_o/oup_data_o/oup_sel_o/oup_ready_i   joined beat; unselected lanes read as 0
module stream_join_buffered #(
   parameter int N_INP      = 2,
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 2
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [N_INP-1:0]            inp_valid_i,
   input  logic [N_INP*DATA_WIDTH-1:0] inp_data_i,
   output logic [N_INP-1:0]            inp_ready_o,
   input  logic                        sel_valid_i,
   input  logic [N_INP-1:0]            sel_i,
   output logic                        sel_ready_o,
   output logic                        oup_valid_o,
   output logic [N_INP*DATA_WIDTH-1:0] oup_data_o,
   output logic [N_INP-1:0]            oup_sel_o,
   input  logic                        oup_ready_i
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

   logic [DATA_WIDTH-1:0] mem_q  [N_INP][DEPTH];
   logic [DATA_WIDTH-1:0] mem_d  [N_INP][DEPTH];
   logic [PW-1:0]         rptr_q [N_INP];
   logic [PW-1:0]         rptr_d [N_INP];
   logic [PW-1:0]         wptr_q [N_INP];
   logic [PW-1:0]         wptr_d [N_INP];
   logic [CW-1:0]         cnt_q  [N_INP];
   logic [CW-1:0]         cnt_d  [N_INP];
   logic                  sel_full_q, sel_full_d;
   logic [N_INP-1:0]      sel_q, sel_d;
   logic [N_INP-1:0]      push, pop, have;
   logic                  fire, load;

   // wraps explicitly so non-power-of-two depths never index past the last entry
   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      for (int k = 0; k < N_INP; k++) begin
         // readiness looks only at the registered count, keeping the consumer out of the ready path
         inp_ready_o[k] = ~rst_i & (cnt_q[k] != CW'(DEPTH));
         push[k]        = inp_valid_i[k] & inp_ready_o[k];
         have[k]        = ~sel_q[k] | (cnt_q[k] != '0);
      end
      oup_valid_o = ~rst_i & sel_full_q & (&have);
      fire        = oup_valid_o & oup_ready_i;
      // a firing beat frees the mask slot in the same cycle for back-to-back masks
      sel_ready_o = ~rst_i & (~sel_full_q | fire);
      load        = sel_valid_i & sel_ready_o;
      pop         = fire ? sel_q : '0;
      sel_full_d  = load | (sel_full_q & ~fire);
      sel_d       = load ? sel_i : sel_q;
      oup_sel_o   = (~rst_i & sel_full_q) ? sel_q : '0;
      oup_data_o  = '0;
      mem_d       = mem_q;
      for (int k = 0; k < N_INP; k++) begin
         oup_data_o[k*DATA_WIDTH +: DATA_WIDTH] = oup_sel_o[k] ? mem_q[k][rptr_q[k]] : '0;
         if (push[k]) mem_d[k][wptr_q[k]] = inp_data_i[k*DATA_WIDTH +: DATA_WIDTH];
         wptr_d[k] = push[k] ? nxt(wptr_q[k]) : wptr_q[k];
         rptr_d[k] = pop[k] ? nxt(rptr_q[k]) : rptr_q[k];
         cnt_d[k]  = (push[k] & ~pop[k]) ? cnt_q[k] + CW'(1) :
                     (pop[k] & ~push[k]) ? cnt_q[k] - CW'(1) : cnt_q[k];
      end
   end

   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
      if (rst_i) begin
         rptr_q     <= '{default: '0};
         wptr_q     <= '{default: '0};
         cnt_q      <= '{default: '0};
         sel_full_q <= 1'b0;
         sel_q      <= '0;
      end else begin
         rptr_q     <= rptr_d;
         wptr_q     <= wptr_d;
         cnt_q      <= cnt_d;
         sel_full_q <= sel_full_d;
         sel_q      <= sel_d;
      end
   end
endmodule
